station_arbiter: RTL and testbench

- Shares the player's single interaction channel and the shared 12-bit kitchen inventory between N cooking stations (stove, chop, ...).
- Uses round-robin arbitration with a frame-counted hold timeout.
- Sits in the top level between the debounced-button/station logic and the station draw modules.
- Replaces the direct wiring of one inventory register to every station: only the granted station may write the inventory.

---
 rtl/station_arbiter.sv | 139 +++++++++++++
 tb/tb_station_arbiter.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/station_arbiter.sv
// Round-robin owner arbitration for cooking stations sharing the player channel and the
// 12-bit kitchen inventory; grants time out after HOLD_FRAMES frame ticks.
module station_arbiter #(
  parameter int unsigned N_STATIONS  = 2,
  parameter int unsigned HOLD_FRAMES = 36,
  parameter logic [11:0] INV_INIT    = 12'h000
) (
  input  logic                       basys_clk,
  input  logic                       reset,
  input  logic                       frame_tick,
  input  logic [N_STATIONS-1:0]      req,
  input  logic [N_STATIONS-1:0]      done,
  input  logic [N_STATIONS-1:0]      wr_en,
  input  logic [12*N_STATIONS-1:0]   wr_data,
  output logic [N_STATIONS-1:0]      grant,
  output logic                       busy,
  output logic [11:0]                inventory,
  output logic                       timeout_pulse
);

  localparam int unsigned IdxW = (N_STATIONS > 2) ? 2 : 1;
  localparam int unsigned CandW = IdxW + 1;
  localparam logic HoldEn = (HOLD_FRAMES != 0);
  localparam logic [7:0] HoldLast = 8'((HOLD_FRAMES == 0) ? 0 : HOLD_FRAMES - 1);

  typedef enum logic [1:0] {StIdle, StOwn, StGap} state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       ptr_q, ptr_d;
  logic [IdxW-1:0]       owner_q, owner_d;
  logic [7:0]            hold_cnt_q, hold_cnt_d;
  logic [N_STATIONS-1:0] grant_q, grant_d;
  logic [11:0]           inv_q, inv_d;
  logic                  tp_q, tp_d;

  logic                  sel_found;
  logic [IdxW-1:0]       sel_idx;
  logic [CandW-1:0]      cand;
  logic [IdxW-1:0]       cand_idx;
  logic                  release_own;
  logic                  timeout_hit;

  // First requester at or after ptr, wrapping past the last station.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    cand_idx  = '0;
    for (int unsigned i = 0; i < N_STATIONS; i++) begin
      cand = {1'b0, ptr_q} + CandW'(i);
      if (cand >= CandW'(N_STATIONS)) begin
        cand = cand - CandW'(N_STATIONS);
      end
      cand_idx = cand[IdxW-1:0];
      if (!sel_found && req[cand_idx]) begin
        sel_found = 1'b1;
        sel_idx   = cand_idx;
      end
    end
  end

  assign release_own = done[owner_q] || !req[owner_q];
  assign timeout_hit = HoldEn && frame_tick && (hold_cnt_q == HoldLast);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    hold_cnt_d = hold_cnt_q;
    grant_d    = grant_q;
    inv_d      = inv_q;
    tp_d       = 1'b0;

    // grant_q is non-zero only in StOwn, so this also blocks writes in StIdle/StGap.
    for (int unsigned i = 0; i < N_STATIONS; i++) begin
      if (wr_en[i] && grant_q[i]) begin
        inv_d = wr_data[12*i +: 12];
      end
    end

    case (state_q)
      StIdle: begin
        grant_d = '0;
        if (sel_found) begin
          grant_d[sel_idx] = 1'b1;
          owner_d          = sel_idx;
          hold_cnt_d       = '0;
          state_d          = StOwn;
        end
      end
      StOwn: begin
        if (frame_tick && (hold_cnt_q != 8'hFF)) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
        if (release_own || timeout_hit) begin
          grant_d = '0;
          state_d = StGap;
          ptr_d   = (owner_q == IdxW'(N_STATIONS - 1)) ? '0 : owner_q + IdxW'(1);
          // A voluntary release takes precedence over a coincident timeout.
          tp_d    = timeout_hit && !release_own;
        end
      end
      StGap: begin
        grant_d = '0;
        state_d = StIdle;
      end
      default: begin
        grant_d = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge basys_clk) begin
    if (reset) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      owner_q    <= '0;
      hold_cnt_q <= '0;
      grant_q    <= '0;
      inv_q      <= INV_INIT;
      tp_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      hold_cnt_q <= hold_cnt_d;
      grant_q    <= grant_d;
      inv_q      <= inv_d;
      tp_q       <= tp_d;
    end
  end

  assign grant         = grant_q;
  assign busy          = |grant_q;
  assign inventory     = inv_q;
  assign timeout_pulse = tp_q;

endmodule

// File: tb/tb_station_arbiter.sv
// Scoreboard bench for station_arbiter: directed steps queue expected outputs, a negedge
// monitor pops and compares them in the cycle they are due.
module tb_station_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic [1:0]  req = '0;
  logic [1:0]  done = '0;
  logic [1:0]  wr_en = '0;
  logic [23:0] wr_data = '0;
  logic [1:0]  grant;
  logic        busy;
  logic [11:0] inventory;
  logic        timeout_pulse;

  int unsigned cyc = 0;
  int          vectors = 0;
  int          fails = 0;

  typedef struct {
    int unsigned at;
    string       name;
    logic [1:0]  g;
    logic        b;
    logic [11:0] inv;
    logic        tp;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  station_arbiter #(
    .N_STATIONS (2),
    .HOLD_FRAMES(3),
    .INV_INIT   (12'h000)
  ) dut (
    .basys_clk    (clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .req          (req),
    .done         (done),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .grant        (grant),
    .busy         (busy),
    .inventory    (inventory),
    .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      mon_e = sb.pop_front();
      vectors++;
      if (mon_e.at != cyc || grant !== mon_e.g || busy !== mon_e.b ||
          inventory !== mon_e.inv || timeout_pulse !== mon_e.tp) begin
        fails++;
        $display("FAIL %s @%0d: got grant=%b busy=%b inv=%h tp=%b, want grant=%b busy=%b inv=%h tp=%b",
                 mon_e.name, cyc, grant, busy, inventory, timeout_pulse,
                 mon_e.g, mon_e.b, mon_e.inv, mon_e.tp);
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected right after the next edge.
  task automatic step(input string nm, input logic rs, input logic [1:0] rq,
                      input logic [1:0] dn, input logic [1:0] we, input logic [11:0] d0,
                      input logic [11:0] d1, input logic tk, input logic [1:0] eg,
                      input logic [11:0] ei, input logic et);
    exp_t e;
    @(posedge clk);
    #1;
    reset      = rs;
    req        = rq;
    done       = dn;
    wr_en      = we;
    wr_data    = {d1, d0};
    frame_tick = tk;
    e.at   = cyc + 1;
    e.name = nm;
    e.g    = eg;
    e.b    = |eg;
    e.inv  = ei;
    e.tp   = et;
    sb.push_back(e);
  endtask

  initial begin
    //    name           rst req   done  wr_en d0      d1      tk   grant inv     tp
    step("reset",        1, 2'b00, 2'b00, 2'b00, 12'h000, 12'h000, 0, 2'b00, 12'h000, 0);
    step("req0_lat1",    0, 2'b01, 2'b00, 2'b00, 12'h000, 12'h000, 0, 2'b01, 12'h000, 0);
    step("hold0",        0, 2'b01, 2'b00, 2'b00, 12'h000, 12'h000, 0, 2'b01, 12'h000, 0);
    step("drop0",        0, 2'b00, 2'b00, 2'b00, 12'h000, 12'h000, 0, 2'b00, 12'h000, 0);
    step("idle",         0, 2'b00, 2'b00, 2'b00, 12'h000, 12'h000, 0, 2'b00, 12'h000, 0);
    step("reset2",       1, 2'b00, 2'b00, 2'b00, 12'h000, 12'h000, 0, 2'b00, 12'h000, 0);
    step("both_req",     0, 2'b11, 2'b00, 2'b00, 12'h000, 12'h000, 0, 2'b01, 12'h000, 0);
    step("done0",        0, 2'b11, 2'b01, 2'b00, 12'h000, 12'h000, 0, 2'b00, 12'h000, 0);
    step("gap_hold",     0, 2'b11, 2'b00, 2'b00, 12'h000, 12'h000, 0, 2'b00, 12'h000, 0);
    step("rr_to1",       0, 2'b11, 2'b00, 2'b00, 12'h000, 12'h000, 0, 2'b10, 12'h000, 0);
    step("wr_owner1",    0, 2'b11, 2'b00, 2'b11, 12'hFFF, 12'h5A3, 0, 2'b10, 12'h5A3, 0);
    step("wr_nonowner",  0, 2'b11, 2'b00, 2'b01, 12'hFFF, 12'h000, 0, 2'b10, 12'h5A3, 0);
    step("done_nonown",  0, 2'b11, 2'b01, 2'b00, 12'h000, 12'h000, 0, 2'b10, 12'h5A3, 0);
    step("done1_wr",     0, 2'b11, 2'b10, 2'b10, 12'h000, 12'h123, 0, 2'b00, 12'h123, 0);
    step("gap2",         0, 2'b11, 2'b00, 2'b00, 12'h000, 12'h000, 0, 2'b00, 12'h123, 0);
    step("rr_to0",       0, 2'b11, 2'b00, 2'b00, 12'h000, 12'h000, 0, 2'b01, 12'h123, 0);
    step("tick1",        0, 2'b11, 2'b00, 2'b00, 12'h000, 12'h000, 1, 2'b01, 12'h123, 0);
    step("tick2",        0, 2'b01, 2'b00, 2'b00, 12'h000, 12'h000, 1, 2'b01, 12'h123, 0);
    step("tick3_tmo",    0, 2'b01, 2'b00, 2'b00, 12'h000, 12'h000, 1, 2'b00, 12'h123, 1);
    step("tmo_gap",      0, 2'b11, 2'b00, 2'b00, 12'h000, 12'h000, 0, 2'b00, 12'h123, 0);
    step("ptr_is1",      0, 2'b11, 2'b00, 2'b00, 12'h000, 12'h000, 0, 2'b10, 12'h123, 0);
    step("drop1",        0, 2'b01, 2'b00, 2'b00, 12'h000, 12'h000, 0, 2'b00, 12'h123, 0);
    step("gap4",         0, 2'b01, 2'b00, 2'b00, 12'h000, 12'h000, 0, 2'b00, 12'h123, 0);
    step("own0",         0, 2'b01, 2'b00, 2'b00, 12'h000, 12'h000, 0, 2'b01, 12'h123, 0);
    step("t1",           0, 2'b01, 2'b00, 2'b00, 12'h000, 12'h000, 1, 2'b01, 12'h123, 0);
    step("t2",           0, 2'b01, 2'b00, 2'b00, 12'h000, 12'h000, 1, 2'b01, 12'h123, 0);
    step("t3_with_done", 0, 2'b01, 2'b01, 2'b00, 12'h000, 12'h000, 1, 2'b00, 12'h123, 0);
    step("gap5",         0, 2'b01, 2'b00, 2'b00, 12'h000, 12'h000, 0, 2'b00, 12'h123, 0);
    step("own0b",        0, 2'b01, 2'b00, 2'b00, 12'h000, 12'h000, 0, 2'b01, 12'h123, 0);
    step("wr0_5a3",      0, 2'b01, 2'b00, 2'b01, 12'h5A3, 12'h000, 0, 2'b01, 12'h5A3, 0);
    step("reset_mid",    1, 2'b01, 2'b00, 2'b00, 12'h000, 12'h000, 0, 2'b00, 12'h000, 0);
    step("after_reset",  0, 2'b11, 2'b00, 2'b00, 12'h000, 12'h000, 0, 2'b01, 12'h000, 0);
    step("release_end",  0, 2'b00, 2'b00, 2'b00, 12'h000, 12'h000, 0, 2'b00, 12'h000, 0);
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
